// File: rtl/btb_set_assoc_pkg.sv
// Shared BTB types, default geometry and saturating-counter helpers.
// Counter helpers work on 8-bit carriers so any CTR_W up to 8 can reuse them.
package btb_set_assoc_pkg;

  localparam int BTB_PC_W  = 16;
  localparam int BTB_SETS  = 16;
  localparam int BTB_WAYS  = 2;
  localparam int BTB_CTR_W = 2;
  localparam int BTB_IDX_W = $clog2(BTB_SETS);
  localparam int BTB_TAG_W = BTB_PC_W - BTB_IDX_W;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_CTR_W-1:0] ctr;
    logic [BTB_PC_W-1:0]  target;
  } btb_entry_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] max);
    return (v >= max) ? max : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

endpackage

// File: rtl/btb_set_assoc_plru.sv
// Tree pseudo-LRU with one WAYS-1 bit tree per set, heap-indexed from node 1.
// A node bit of 0 steers the victim search left; touching a way points every node on its path away from it.
module plru_tree #(
  parameter int WAYS = 2,
  parameter int SETS = 16,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             touch_valid,
  input  logic [IDX_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [IDX_W-1:0] victim_set,
  output logic [WAY_W-1:0] victim_way
);

  if (WAYS == 1) begin : g_direct
    logic unused_inputs;
    assign unused_inputs = ^{clk, n_rst, flush, touch_valid, touch_set, touch_way, victim_set};
    assign victim_way    = '0;
  end else begin : g_tree
    logic [WAYS-1:1] bits_q [SETS];
    logic [WAYS-1:1] bits_touched;

    always_comb begin
      int node;
      bits_touched = bits_q[touch_set];
      node = 1;
      for (int l = 0; l < WAY_W; l++) begin
        bits_touched[node] = ~touch_way[WAY_W-1-l];
        node = 2 * node + int'(touch_way[WAY_W-1-l]);
      end
    end

    always_comb begin
      int node;
      node = 1;
      for (int l = 0; l < WAY_W; l++) begin
        node = 2 * node + int'(bits_q[victim_set][node]);
      end
      victim_way = WAY_W'(node - WAYS);
    end

    always_ff @(posedge clk) begin
      if (!n_rst || flush) begin
        for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
      end else if (touch_valid) begin
        bits_q[touch_set] <= bits_touched;
      end
    end
  end

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative BTB: same-cycle lookup for fetch, single-edge training/allocation from execute.
// Feedback is not bypassed to the lookup port; the fetch side sees updates one cycle later.
module btb_set_assoc
  import btb_set_assoc_pkg::*;
#(
  parameter int PC_W  = BTB_PC_W,
  parameter int SETS  = BTB_SETS,
  parameter int WAYS  = BTB_WAYS,
  parameter int CTR_W = BTB_CTR_W
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [PC_W-1:0] pc,
  output logic            hit,
  output logic            predict_taken,
  output logic [PC_W-1:0] target,
  input  logic            fb_valid,
  input  logic [PC_W-1:0] fb_pc,
  input  logic            fb_is_branch,
  input  logic            fb_taken,
  input  logic [PC_W-1:0] fb_target,
  input  logic            flush
);

  localparam int IDX_W    = $clog2(SETS);
  localparam int TAG_W    = PC_W - IDX_W;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CTR_MAX  = (1 << CTR_W) - 1;
  localparam int CTR_INIT = 1 << (CTR_W - 1);

  logic             valid_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [CTR_W-1:0] ctr_q   [SETS][WAYS];
  logic [PC_W-1:0]  tgt_q   [SETS][WAYS];

  logic [IDX_W-1:0] idx, fb_idx;
  logic [TAG_W-1:0] tag, fb_tag;
  logic [WAYS-1:0]  way_hit, fb_way_hit;
  logic [WAY_W-1:0] hit_way, fb_hit_way, alloc_way, plru_victim;
  logic             fb_hit, fb_train, fb_evict, fb_alloc;
  logic [CTR_W-1:0] ctr_cur, ctr_next;

  assign idx    = pc[IDX_W-1:0];
  assign tag    = pc[PC_W-1:IDX_W];
  assign fb_idx = fb_pc[IDX_W-1:0];
  assign fb_tag = fb_pc[PC_W-1:IDX_W];

  // Parallel tag compare; the OR-encoder is exact because allocation keeps hits one-hot.
  always_comb begin
    way_hit    = '0;
    fb_way_hit = '0;
    hit_way    = '0;
    fb_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w]    = valid_q[idx][w] && (tag_q[idx][w] == tag);
      fb_way_hit[w] = valid_q[fb_idx][w] && (tag_q[fb_idx][w] == fb_tag);
      if (way_hit[w])    hit_way    = hit_way | WAY_W'(w);
      if (fb_way_hit[w]) fb_hit_way = fb_hit_way | WAY_W'(w);
    end
  end

  assign hit           = |way_hit;
  assign predict_taken = hit & ctr_q[idx][hit_way][CTR_W-1];
  assign target        = hit ? tgt_q[idx][hit_way] : '0;

  // Empty ways are filled lowest-first before the PLRU choice is consulted.
  always_comb begin
    logic found;
    found     = 1'b0;
    alloc_way = plru_victim;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[fb_idx][w]) begin
        alloc_way = WAY_W'(w);
        found     = 1'b1;
      end
    end
  end

  assign fb_hit   = |fb_way_hit;
  assign fb_train = fb_valid & fb_hit & fb_is_branch;
  assign fb_evict = fb_valid & fb_hit & ~fb_is_branch;
  assign fb_alloc = fb_valid & ~fb_hit & fb_is_branch & fb_taken;

  assign ctr_cur  = ctr_q[fb_idx][fb_hit_way];
  assign ctr_next = fb_taken ? CTR_W'(sat_inc(8'(ctr_cur), 8'(CTR_MAX)))
                             : CTR_W'(sat_dec(8'(ctr_cur)));

  plru_tree #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk         (clk),
    .n_rst       (n_rst),
    .flush       (flush),
    .touch_valid (~flush & (fb_train | fb_alloc)),
    .touch_set   (fb_idx),
    .touch_way   (fb_hit ? fb_hit_way : alloc_way),
    .victim_set  (fb_idx),
    .victim_way  (plru_victim)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          ctr_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      if (fb_train) begin
        ctr_q[fb_idx][fb_hit_way] <= ctr_next;
        if (fb_taken) tgt_q[fb_idx][fb_hit_way] <= fb_target;
      end
      if (fb_evict) valid_q[fb_idx][fb_hit_way] <= 1'b0;
      if (fb_alloc) begin
        valid_q[fb_idx][alloc_way] <= 1'b1;
        tag_q[fb_idx][alloc_way]   <= fb_tag;
        tgt_q[fb_idx][alloc_way]   <= fb_target;
        ctr_q[fb_idx][alloc_way]   <= CTR_W'(CTR_INIT);
      end
    end
  end

  a_lookup_onehot: assert property (@(posedge clk) disable iff (!n_rst) $onehot0(way_hit));
  a_fb_onehot:     assert property (@(posedge clk) disable iff (!n_rst) $onehot0(fb_way_hit));
  a_no_x_out:      assert property (@(posedge clk) disable iff (!n_rst)
                                    !$isunknown({hit, predict_taken, target}));

endmodule

// File: tb/tb_btb_set_assoc.sv
// Bench for btb_set_assoc: directed scenarios plus random feedback traffic against a true-LRU entry model.
// For two ways tree-PLRU and true LRU pick the same victim, so the model tracks only the MRU way per set.
module tb_btb_set_assoc;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [15:0] pc;
  logic        hit, predict_taken;
  logic [15:0] target;
  logic        fb_valid, fb_is_branch, fb_taken, flush;
  logic [15:0] fb_pc, fb_target;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  btb_set_assoc #(.PC_W(16), .SETS(16), .WAYS(2), .CTR_W(2)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .pc            (pc),
    .hit           (hit),
    .predict_taken (predict_taken),
    .target        (target),
    .fb_valid      (fb_valid),
    .fb_pc         (fb_pc),
    .fb_is_branch  (fb_is_branch),
    .fb_taken      (fb_taken),
    .fb_target     (fb_target),
    .flush         (flush)
  );

  // Reference model: entries per set/way, counter as plain integer, MRU way per set.
  bit          m_valid [16][2];
  logic [11:0] m_tag   [16][2];
  int          m_ctr   [16][2];
  logic [15:0] m_tgt   [16][2];
  int          m_mru   [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int model_find(input logic [15:0] p);
    for (int w = 0; w < 2; w++)
      if (m_valid[p[3:0]][w] && m_tag[p[3:0]][w] == p[15:4]) return w;
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0; m_tag[s][w] = '0; m_ctr[s][w] = 0; m_tgt[s][w] = '0;
      end
      m_mru[s] = 1;  // no history: way 0 is the LRU choice
    end
  endtask

  task automatic model_edge(input bit fv, input logic [15:0] fp, input bit br, input bit tk,
                            input logic [15:0] ft, input bit fl, input bit rs);
    int s, w, v;
    s = int'(fp[3:0]);
    if (!rs) model_reset();
    else if (fl) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i][0] = 0; m_valid[i][1] = 0; m_mru[i] = 1;
      end
    end else if (fv) begin
      w = model_find(fp);
      if (w >= 0 && br) begin
        m_ctr[s][w] = tk ? ((m_ctr[s][w] == 3) ? 3 : m_ctr[s][w] + 1)
                         : ((m_ctr[s][w] == 0) ? 0 : m_ctr[s][w] - 1);
        if (tk) m_tgt[s][w] = ft;
        m_mru[s] = w;
      end else if (w >= 0) begin
        m_valid[s][w] = 0;
      end else if (br && tk) begin
        if (!m_valid[s][0]) v = 0;
        else if (!m_valid[s][1]) v = 1;
        else v = 1 - m_mru[s];
        m_valid[s][v] = 1; m_tag[s][v] = fp[15:4]; m_tgt[s][v] = ft; m_ctr[s][v] = 2;
        m_mru[s] = v;
      end
    end
  endtask

  // One clock: drive, compare lookup against the pre-edge model, then advance the model at the edge.
  task automatic cycle(input logic [15:0] p, input bit fv, input logic [15:0] fp, input bit br,
                       input bit tk, input logic [15:0] ft, input bit fl, input bit rs);
    int w;
    @(negedge clk);
    pc = p; fb_valid = fv; fb_pc = fp; fb_is_branch = br; fb_taken = tk;
    fb_target = ft; flush = fl; n_rst = rs;
    #1;
    w = model_find(p);
    check("model_hit", 32'(hit), 32'(w >= 0));
    check("model_taken", 32'(predict_taken), (w >= 0) ? 32'(m_ctr[p[3:0]][w] >= 2) : 32'd0);
    check("model_target", 32'(target), (w >= 0) ? 32'(m_tgt[p[3:0]][w]) : 32'd0);
    @(posedge clk);
    model_edge(fv, fp, br, tk, ft, fl, rs);
  endtask

  task automatic fb(input logic [15:0] fp, input bit br, input bit tk, input logic [15:0] ft);
    cycle(16'h0000, 1'b1, fp, br, tk, ft, 1'b0, 1'b1);
  endtask

  // Lookup-only cycle with fixed expectations from the scenario description.
  task automatic expect_lookup(input string name, input logic [15:0] p, input bit eh,
                               input bit et, input logic [15:0] etgt);
    @(negedge clk);
    pc = p; fb_valid = 1'b0; flush = 1'b0; n_rst = 1'b1;
    #1;
    check({name, "_hit"}, 32'(hit), 32'(eh));
    check({name, "_taken"}, 32'(predict_taken), 32'(et));
    check({name, "_target"}, 32'(target), 32'(etgt));
  endtask

  initial begin
    pc = '0; fb_valid = 0; fb_pc = '0; fb_is_branch = 0; fb_taken = 0;
    fb_target = '0; flush = 0; n_rst = 0;
    model_reset();
    repeat (2) cycle(16'h0034, 0, '0, 0, 0, '0, 0, 0);

    // 1: reset state
    expect_lookup("reset", 16'h0034, 0, 0, 16'h0000);

    // 2: allocate, no same-cycle bypass
    cycle(16'h0034, 1, 16'h0034, 1, 1, 16'h0100, 0, 1);
    expect_lookup("alloc", 16'h0034, 1, 1, 16'h0100);

    // 3: saturate down, then retrain up with a new target
    repeat (3) fb(16'h0034, 1, 0, 16'h0999);
    expect_lookup("sat_low", 16'h0034, 1, 0, 16'h0100);
    repeat (2) fb(16'h0034, 1, 1, 16'h0200);
    expect_lookup("retrain", 16'h0034, 1, 1, 16'h0200);

    // 4: LRU eviction within set 4
    cycle(16'h0000, 1, 16'h0000, 1, 1, 16'h0000, 0, 0);
    fb(16'h0034, 1, 1, 16'h0100);
    fb(16'h0134, 1, 1, 16'h0300);
    fb(16'h0034, 1, 1, 16'h0100);
    fb(16'h0234, 1, 1, 16'h0400);
    expect_lookup("lru_keep", 16'h0034, 1, 1, 16'h0100);
    expect_lookup("lru_new", 16'h0234, 1, 1, 16'h0400);
    expect_lookup("lru_evict", 16'h0134, 0, 0, 16'h0000);

    // 5: alias eviction and no allocation on not-taken miss
    fb(16'h0034, 0, 0, 16'h0000);
    expect_lookup("alias", 16'h0034, 0, 0, 16'h0000);
    fb(16'h0050, 1, 0, 16'h0700);
    expect_lookup("nt_miss", 16'h0050, 0, 0, 16'h0000);

    // 6: flush beats feedback; reset beats training
    cycle(16'h0234, 1, 16'h0060, 1, 1, 16'h0800, 1, 1);
    expect_lookup("flush_old", 16'h0234, 0, 0, 16'h0000);
    expect_lookup("flush_fb", 16'h0060, 0, 0, 16'h0000);
    fb(16'h0070, 1, 1, 16'h0900);
    cycle(16'h0070, 1, 16'h0070, 1, 1, 16'h0a00, 0, 0);
    expect_lookup("rst_train", 16'h0070, 0, 0, 16'h0000);

    // Random traffic over a few tags in a few sets to force conflicts
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] rp, rf, rt;
      rp = {8'h00, 4'(($urandom_range(0, 3))), 4'(($urandom_range(0, 3)))};
      rf = {8'h00, 4'(($urandom_range(0, 3))), 4'(($urandom_range(0, 3)))};
      rt = 16'($urandom);
      cycle(rp, $urandom_range(0, 9) < 7, rf, $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) < 6, rt, $urandom_range(0, 199) == 0,
            $urandom_range(0, 399) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
